// File: rtl/digits_rom_arbiter.sv
// digits_rom_arbiter
//   Round-robin arbiter sharing one combinational 5x5 digit-bitmap ROM between
//   NREQ renderers. One lookup is accepted per clock; the ROM address is
//   registered, and the returned row bits are registered and routed back to the
//   winning requester with a one-hot valid pulse (2-edge latency).
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   req        in   [NREQ]     per-requester lookup request (level)
//   req_digit  in   [4*NREQ]   digit of requester i at [4i+3:4i]
//   req_yofs   in   [3*NREQ]   row of requester i at [3i+2:3i]
//   gnt        out  [NREQ]     one-hot combinational grant
//   rom_digit  out  [4]        registered ROM digit address
//   rom_yofs   out  [3]        registered ROM row address
//   rom_bits   in   [5]        combinational ROM row data
//   rsp_valid  out  [NREQ]     one-hot registered response pulse
//   rsp_bits   out  [5]        registered row bits
//   rsp_err    out             registered out-of-range flag
//
// Build option: define DIGITS_RANGE_CHECK_EN to flag lookups with digit > 9 or
// row > 4 (response bits forced to zero, rsp_err set). Without it rsp_err is 0.

module digits_rom_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_digit,
  input  logic [3*NREQ-1:0] req_yofs,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        rom_digit,
  output logic [2:0]        rom_yofs,
  input  logic [4:0]        rom_bits,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [4:0]        rsp_bits,
  output logic              rsp_err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDXW-1:0] last_gnt_q, last_gnt_d;
  logic [IDXW-1:0] tag_q, tag_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s1_oor_q, s1_oor_d;
  logic [3:0]      rom_digit_q, rom_digit_d;
  logic [2:0]      rom_yofs_q, rom_yofs_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [4:0]      rsp_bits_q, rsp_bits_d;
  logic            rsp_err_q, rsp_err_d;

  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW:0]   cand;
  logic [3:0]      sel_digit;
  logic [2:0]      sel_yofs;
  logic            sel_oor;

  // Round-robin search: walk from last_gnt+1 around to last_gnt itself, so the
  // previous winner has lowest priority. cand is one bit wider so the sum can
  // be wrapped with a single conditional subtract.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_gnt_q;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_gnt_q} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NREQ)) cand = cand - (IDXW+1)'(NREQ);
      if (!win_found && req[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
    // No grant (and hence no acceptance) while reset is asserted.
    if (!reset_n) win_found = 1'b0;
  end

  assign gnt       = win_found ? (NREQ'(1) << win_idx) : '0;
  assign sel_digit = req_digit[{win_idx, 2'b00} +: 4];
  assign sel_yofs  = req_yofs[int'(win_idx) * 3 +: 3];

`ifdef DIGITS_RANGE_CHECK_EN
  assign sel_oor = (sel_digit > 4'd9) || (sel_yofs > 3'd4);
`else
  assign sel_oor = 1'b0;
`endif

  always_comb begin
    last_gnt_d  = last_gnt_q;
    tag_d       = tag_q;
    s1_valid_d  = win_found;
    s1_oor_d    = s1_oor_q;
    rom_digit_d = rom_digit_q;
    rom_yofs_d  = rom_yofs_q;
    rsp_valid_d = '0;
    rsp_bits_d  = rsp_bits_q;
    rsp_err_d   = rsp_err_q;

    if (win_found) begin
      last_gnt_d  = win_idx;
      tag_d       = win_idx;
      s1_oor_d    = sel_oor;
      rom_digit_d = sel_digit;
      rom_yofs_d  = sel_yofs;
    end

    // Stage 2: capture ROM data for the lookup addressed last cycle. An
    // out-of-range lookup still drives the ROM but returns zeros.
    if (s1_valid_q) begin
      rsp_valid_d = NREQ'(1) << tag_q;
      rsp_bits_d  = s1_oor_q ? 5'b00000 : rom_bits;
      rsp_err_d   = s1_oor_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_gnt_q  <= IDXW'(NREQ - 1);
      tag_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_oor_q    <= 1'b0;
      rom_digit_q <= '0;
      rom_yofs_q  <= '0;
      rsp_valid_q <= '0;
      rsp_bits_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      tag_q       <= tag_d;
      s1_valid_q  <= s1_valid_d;
      s1_oor_q    <= s1_oor_d;
      rom_digit_q <= rom_digit_d;
      rom_yofs_q  <= rom_yofs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bits_q  <= rsp_bits_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rom_digit = rom_digit_q;
  assign rom_yofs  = rom_yofs_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bits  = rsp_bits_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_digits_rom_arbiter.sv
// tb_digits_rom_arbiter
//   Randomized and directed bench for digits_rom_arbiter with NREQ=2. The bench
//   owns the digit ROM (a 5x5 font table) and a behavioural model: grants are
//   found by a modulo search from the last winner, accepted lookups are queued
//   with the cycle their response is due.

module tb_digits_rom_arbiter;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_digit;
  logic [3*NREQ-1:0] req_yofs;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        rom_digit;
  logic [2:0]        rom_yofs;
  logic [4:0]        rom_bits;
  logic [NREQ-1:0]   rsp_valid;
  logic [4:0]        rsp_bits;
  logic              rsp_err;

  digits_rom_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_digit(req_digit),
    .req_yofs(req_yofs), .gnt(gnt), .rom_digit(rom_digit), .rom_yofs(rom_yofs),
    .rom_bits(rom_bits), .rsp_valid(rsp_valid), .rsp_bits(rsp_bits),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Font ROM: 5 rows of 5 bits, row 0 first. Codes 10-15 and rows 5-7 return
  // arbitrary but deterministic data.
  function automatic logic [4:0] rom_model(input logic [3:0] d, input logic [2:0] y);
    logic [24:0] g;
    case (d)
      4'd0: g = {5'b11111, 5'b10001, 5'b10001, 5'b10001, 5'b11111};
      4'd1: g = {5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      4'd2: g = {5'b11111, 5'b00001, 5'b11111, 5'b10000, 5'b11111};
      4'd3: g = {5'b11111, 5'b00001, 5'b11111, 5'b00001, 5'b11111};
      4'd4: g = {5'b10001, 5'b10001, 5'b11111, 5'b00001, 5'b00001};
      4'd5: g = {5'b11111, 5'b10000, 5'b11111, 5'b00001, 5'b11111};
      4'd6: g = {5'b11111, 5'b10000, 5'b11111, 5'b10001, 5'b11111};
      4'd7: g = {5'b11111, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
      4'd8: g = {5'b11111, 5'b10001, 5'b11111, 5'b10001, 5'b11111};
      4'd9: g = {5'b11111, 5'b10001, 5'b11111, 5'b00001, 5'b11111};
      default: g = {5'b10101, 5'b01010, 5'b10101, 5'b01010, 5'b10101};
    endcase
    if (y > 3'd4) return {y, d[1:0]} ^ 5'b01010;
    return g[24 - 5 * int'(y) -: 5];
  endfunction

  assign rom_bits = rom_model(rom_digit, rom_yofs);

  typedef struct {
    int         due;
    int         idx;
    logic [4:0] bits;
    logic       err;
  } pend_t;

  pend_t           pq[$];
  int              mlast;
  int              cyc;
  logic [NREQ-1:0] exp_valid;
  logic [4:0]      exp_bits;
  logic            exp_err;
  int              n_vec;
  int              n_err;

  function automatic logic [NREQ-1:0] model_gnt();
    if (!reset_n) return '0;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (mlast + k) % NREQ;
      if (req[i]) return NREQ'(1) << i;
    end
    return '0;
  endfunction

  // One clock edge: record what the model accepts, then update expectations.
  task automatic advance();
    logic [NREQ-1:0] g;
    logic            rst;
    pend_t           e;
    logic [3:0]      d;
    logic [2:0]      y;
    g   = model_gnt();
    rst = !reset_n;
    if (rst) begin
      pq.delete();
      mlast = NREQ - 1;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          d = req_digit[4*i +: 4];
          y = req_yofs[3*i +: 3];
`ifdef DIGITS_RANGE_CHECK_EN
          e.err  = (d > 4'd9) || (y > 3'd4);
          e.bits = e.err ? 5'b00000 : rom_model(d, y);
`else
          e.err  = 1'b0;
          e.bits = rom_model(d, y);
`endif
          e.due = cyc + 2;
          e.idx = i;
          pq.push_back(e);
          mlast = i;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      exp_valid = '0;
      exp_bits  = '0;
      exp_err   = 1'b0;
    end else if (pq.size() > 0 && pq[0].due == cyc) begin
      e = pq.pop_front();
      exp_valid = NREQ'(1) << e.idx;
      exp_bits  = e.bits;
      exp_err   = e.err;
    end else begin
      exp_valid = '0;
    end
  endtask

  task automatic set_req(input int i, input logic on, input logic [3:0] d, input logic [2:0] y);
    req[i]             = on;
    req_digit[4*i +: 4] = d;
    req_yofs[3*i +: 3]  = y;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    advance();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req       = '1;
    req_digit = 8'h53;
    req_yofs  = 6'o21;
    #1;
    n_vec++;
    if (gnt !== '0) begin n_err++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    advance();
    advance();
    n_vec++;
    if (rom_digit !== 4'd0 || rom_yofs !== 3'd0) begin
      n_err++; $display("FAIL reset_rom_addr: got %0d/%0d expected 0/0", rom_digit, rom_yofs);
    end
    n_vec++;
    if (rsp_valid !== '0 || rsp_bits !== 5'd0 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp: got v=%b b=%b e=%b expected 00/00000/0", rsp_valid, rsp_bits, rsp_err);
    end
    req     = '0;
    reset_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 4'd8, 3'd1);
    #1;
    n_vec++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b expected 01", gnt); end
    advance();
    req = '0;
    n_vec++;
    if (rom_digit !== 4'd8 || rom_yofs !== 3'd1) begin
      n_err++; $display("FAIL single_rom_addr: got %0d/%0d expected 8/1", rom_digit, rom_yofs);
    end
    n_vec++;
    if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_early: got %b expected 00", rsp_valid); end
    advance();
    n_vec++;
    if (rsp_valid !== 2'b01 || rsp_bits !== 5'b10001 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: got v=%b b=%b e=%b expected 01/10001/0", rsp_valid, rsp_bits, rsp_err);
    end
    advance();
    n_vec++;
    if (rsp_valid !== 2'b00 || rsp_bits !== 5'b10001) begin
      n_err++; $display("FAIL single_pulse: got v=%b b=%b expected 00/10001", rsp_valid, rsp_bits);
    end
    $display("test_single: digit 8 row 1 -> %b", rsp_bits);
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    do_reset();
    set_req(0, 1'b1, 4'd2, 3'd2);
    set_req(1, 1'b1, 4'd3, 3'd2);
    for (int c = 0; c < 7; c++) begin
      if (c == 4) req = '0;
      #1;
      n_vec++;
      if (gnt !== (c < 4 ? seq[c] : 2'b00)) begin
        n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, (c < 4 ? seq[c] : 2'b00));
      end
      advance();
      n_vec++;
      if (rsp_valid !== ((c >= 1 && c < 5) ? seq[c-1] : 2'b00) ||
          ((c >= 1 && c < 5) && rsp_bits !== 5'b11111)) begin
        n_err++; $display("FAIL rr_rsp[%0d]: got v=%b b=%b", c, rsp_valid, rsp_bits);
      end
      $display("test_round_robin: cycle %0d rsp_valid=%b rsp_bits=%b", c, rsp_valid, rsp_bits);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] bits [3];
    bits[0] = 5'b10001; bits[1] = 5'b10001; bits[2] = 5'b11111;
    req = '0;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) set_req(1, 1'b1, 4'd4, 3'(c)); else req = '0;
      #1;
      n_vec++;
      if (gnt !== (c < 3 ? 2'b10 : 2'b00)) begin
        n_err++; $display("FAIL b2b_gnt[%0d]: got %b", c, gnt);
      end
      advance();
      if (c >= 1 && c < 4) begin
        n_vec++;
        if (rsp_valid !== 2'b10 || rsp_bits !== bits[c-1]) begin
          n_err++; $display("FAIL b2b_rsp[%0d]: got v=%b b=%b expected 10/%b", c, rsp_valid, rsp_bits, bits[c-1]);
        end
      end
      $display("test_back_to_back: cycle %0d rsp_valid=%b rsp_bits=%b", c, rsp_valid, rsp_bits);
    end
  endtask

  task automatic test_reset_inflight();
    set_req(0, 1'b1, 4'd0, 3'd0);
    advance();
    req     = '0;
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) reset_n = 1'b1;
      advance();
      n_vec++;
      if (rsp_valid !== 2'b00) begin
        n_err++; $display("FAIL inflight_drop[%0d]: got %b expected 00", c, rsp_valid);
      end
    end
    req = 2'b11;
    #1;
    n_vec++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL inflight_prio: got %b expected 01", gnt); end
    req = '0;
    $display("test_reset_inflight: post-reset grant %b", gnt);
  endtask

  task automatic test_range();
    logic [3:0] ds [3];
    logic [2:0] ys [3];
    logic [4:0] eb [3];
    logic       ee [3];
`ifdef DIGITS_RANGE_CHECK_EN
    ds[0] = 4'd12; ys[0] = 3'd0; eb[0] = 5'b00000; ee[0] = 1'b1;
    ds[1] = 4'd1;  ys[1] = 3'd5; eb[1] = 5'b00000; ee[1] = 1'b1;
    ds[2] = 4'd1;  ys[2] = 3'd0; eb[2] = 5'b01100; ee[2] = 1'b0;
`else
    ds[0] = 4'd7;  ys[0] = 3'd3; eb[0] = 5'b00001; ee[0] = 1'b0;
    ds[1] = 4'd1;  ys[1] = 3'd0; eb[1] = 5'b01100; ee[1] = 1'b0;
    ds[2] = 4'd9;  ys[2] = 3'd3; eb[2] = 5'b00001; ee[2] = 1'b0;
`endif
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) set_req(0, 1'b1, ds[c], ys[c]); else req = '0;
      advance();
      if (c >= 1 && c < 4) begin
        n_vec++;
        if (rsp_valid !== 2'b01 || rsp_bits !== eb[c-1] || rsp_err !== ee[c-1]) begin
          n_err++; $display("FAIL range[%0d]: got v=%b b=%b e=%b expected 01/%b/%b",
                            c - 1, rsp_valid, rsp_bits, rsp_err, eb[c-1], ee[c-1]);
        end
        $display("test_range: lookup %0d rsp_bits=%b rsp_err=%b", c - 1, rsp_bits, rsp_err);
      end
    end
  endtask

  task automatic test_random();
    int              wait_cnt [NREQ];
    logic [NREQ-1:0] g;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    req = '0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        reset_n = 1'b0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
      end
      if (c == 202) reset_n = 1'b1;
      #1;
      g = model_gnt();
      n_vec++;
      if (gnt !== g) begin n_err++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, gnt, g); end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !g[i] && reset_n) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        n_vec++;
        if (wait_cnt[i] > NREQ - 1) begin
          n_err++; $display("FAIL rand_wait[%0d] req %0d: got %0d cycles expected <= %0d", c, i, wait_cnt[i], NREQ - 1);
        end
      end
      advance();
      n_vec++;
      if (rsp_valid !== exp_valid || rsp_bits !== exp_bits || rsp_err !== exp_err) begin
        n_err++; $display("FAIL rand_rsp[%0d]: got v=%b b=%b e=%b expected %b/%b/%b",
                          c, rsp_valid, rsp_bits, rsp_err, exp_valid, exp_bits, exp_err);
      end
      // Requesters obey the hold rule: a waiting request keeps its address.
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || g[i])
          set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      end
    end
    req = '0;
    $display("test_random: 400 cycles, %0d miscompares so far", n_err);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cyc       = 0;
    mlast     = NREQ - 1;
    exp_valid = '0;
    exp_bits  = '0;
    exp_err   = 1'b0;
    reset_n   = 1'b0;
    req       = '0;
    req_digit = '0;
    req_yofs  = '0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_inflight();
    test_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
